// File: rtl/pwm_pkg.sv
// Shared helpers and reset constants for the multichannel PWM block.
// PWM_CENTER_ALIGNED_EN selects the up/down counter mode in pwm_multichannel.
package pwm_pkg;

    localparam logic PWM_IDLE  = 1'b0;
    localparam logic TICK_IDLE = 1'b0;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    // Channel-select width; a single channel still gets a 1-bit select port.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow (pending) duty, active duty loaded at frame boundary,
// and a registered compare against the shared counter.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_counter,
    input  logic             i_load,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_duty,
    output logic             o_pwm
);

    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] r_active;
    logic             r_pwm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else if (i_wr) begin
            r_pending <= i_duty;
        end
    end

    // A write landing on the load cycle is not seen here until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= '0;
        end else if (i_load) begin
            r_active <= r_pending;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= PWM_IDLE;
        end else begin
            r_pwm <= i_enable && (i_counter < r_active);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_multichannel.sv
// N-channel PWM with a shared frame counter and boundary-synchronous duty/period update.
// Define PWM_CENTER_ALIGNED_EN for an up/down (centre-aligned) counter; default is edge-aligned.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int WIDTH    = 16,
    localparam int CH_W     = ch_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [WIDTH-1:0]    period,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_duty,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    logic [WIDTH-1:0]    r_counter;
    logic [WIDTH-1:0]    r_active_period;
    logic                r_tick;
    logic [WIDTH-1:0]    w_eff_period;
    logic [WIDTH-1:0]    w_last;
    logic                w_boundary;
    logic                w_load;
    logic [CHANNELS-1:0] w_wr_sel;

    // A programmed period of 0 behaves as 1, so P-1 never underflows.
    assign w_eff_period = (r_active_period == '0) ? WIDTH'(1) : r_active_period;
    assign w_last       = w_eff_period - WIDTH'(1);

`ifdef PWM_CENTER_ALIGNED_EN
    logic r_dir;

    assign w_boundary = enable && (r_dir == DIR_DOWN) && (r_counter == '0);

    // Up to P-1, hold P-1 for one extra cycle, then down to 0: frame is 2P cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_counter <= '0;
            r_dir     <= DIR_UP;
        end else if (!enable) begin
            r_counter <= '0;
            r_dir     <= DIR_UP;
        end else if (r_dir == DIR_UP) begin
            if (r_counter >= w_last) begin
                r_dir <= DIR_DOWN;
            end else begin
                r_counter <= r_counter + WIDTH'(1);
            end
        end else if (r_counter == '0) begin
            r_dir <= DIR_UP;
        end else begin
            r_counter <= r_counter - WIDTH'(1);
        end
    end
`else
    assign w_boundary = enable && (r_counter >= w_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_counter <= '0;
        end else if (!enable || w_boundary) begin
            r_counter <= '0;
        end else begin
            r_counter <= r_counter + WIDTH'(1);
        end
    end
`endif

    // While disabled the active set tracks the shadow set, so enabling starts a clean frame.
    assign w_load = w_boundary || !enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_period <= '0;
        end else if (w_load) begin
            r_active_period <= period;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= TICK_IDLE;
        end else begin
            r_tick <= w_boundary;
        end
    end

    assign period_tick = r_tick;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        // Out-of-range channel numbers match no slice and are dropped.
        assign w_wr_sel[gi] = wr_en && (32'(wr_ch) == 32'(gi));

        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_channel (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_enable (enable),
            .i_counter(r_counter),
            .i_load   (w_load),
            .i_wr     (w_wr_sel[gi]),
            .i_duty   (wr_duty),
            .o_pwm    (pwm_out[gi])
        );
    end

endmodule
